// File: rtl/seg7_scan_if.sv
// Bundle between the display data source and the 8-digit 7-segment scanner.
// Signal names keep the scanner's _i/_o port naming.
interface seg7_scan_if;
  logic        scan_clk_i;
  logic [31:0] data_i;
  logic [7:0]  dp_i;
  logic [7:0]  en_i;
  logic        load_i;
  logic [7:0]  an_o;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [2:0]  digit_idx_o;

  modport master (
    output scan_clk_i, data_i, dp_i, en_i, load_i,
    input  an_o, seg_o, dp_o, digit_idx_o
  );

  modport slave (
    input  scan_clk_i, data_i, dp_i, en_i, load_i,
    output an_o, seg_o, dp_o, digit_idx_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed 7-segment scanner with anti-ghost blanking
// and frame-synchronous (tear-free) shadow commit.
module seg7_scan_ctrl #(
  parameter int unsigned BLANK_CYC = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  seg7_scan_if.slave bus
);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_e;

  localparam logic [7:0] BCNT_INIT = 8'(BLANK_CYC - 1);

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] p;
    unique case (n)
      4'h0: p = 7'h3F;
      4'h1: p = 7'h06;
      4'h2: p = 7'h5B;
      4'h3: p = 7'h4F;
      4'h4: p = 7'h66;
      4'h5: p = 7'h6D;
      4'h6: p = 7'h7D;
      4'h7: p = 7'h07;
      4'h8: p = 7'h7F;
      4'h9: p = 7'h6F;
      4'hA: p = 7'h77;
      4'hB: p = 7'h7C;
      4'hC: p = 7'h39;
      4'hD: p = 7'h5E;
      4'hE: p = 7'h79;
      4'hF: p = 7'h71;
    endcase
    return p;
  endfunction

  logic [2:0]  s_q;
  state_e      state_q, state_d;
  logic [7:0]  bcnt_q, bcnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] sh_data_q, act_data_q;
  logic [7:0]  sh_dp_q, act_dp_q;
  logic [7:0]  sh_en_q, act_en_q;
  logic        pend_q;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dpo_q, dpo_d;
  logic [2:0]  didx_q;
  logic        step;
  logic        wrap;
  logic [3:0]  nib;

  assign step = s_q[1] & ~s_q[2];
  assign wrap = step & (idx_q == 3'd7);
  assign nib  = act_data_q[{idx_q, 2'b00} +: 4];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      s_q     <= '0;
      state_q <= BLANK;
      bcnt_q  <= BCNT_INIT;
      idx_q   <= '0;
    end else begin
      s_q     <= {s_q[1:0], bus.scan_clk_i};
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      idx_q   <= idx_d;
    end
  end

  // A step always wins, so a step inside BLANK restarts the interval
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    idx_d   = idx_q;
    if (step) begin
      idx_d   = idx_q + 3'd1;
      state_d = BLANK;
      bcnt_d  = BCNT_INIT;
    end else if (state_q == BLANK) begin
      if (bcnt_q == 8'd0) state_d = DRIVE;
      else                bcnt_d  = bcnt_q - 8'd1;
    end
  end

  always_comb begin
    an_d  = 8'hFF;
    seg_d = 7'h7F;
    dpo_d = 1'b1;
    if (state_q == DRIVE) begin
      an_d  = ~({7'b0, act_en_q[idx_q]} << idx_q);
      seg_d = ~hex7(nib);
      dpo_d = ~(act_en_q[idx_q] & act_dp_q[idx_q]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      an_q   <= 8'hFF;
      seg_q  <= 7'h7F;
      dpo_q  <= 1'b1;
      didx_q <= '0;
    end else begin
      an_q   <= an_d;
      seg_q  <= seg_d;
      dpo_q  <= dpo_d;
      didx_q <= idx_q;
    end
  end

  // Commit reads the old shadow, so a load on the wrap cycle waits a frame
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sh_data_q  <= '0;
      sh_dp_q    <= '0;
      sh_en_q    <= '0;
      pend_q     <= 1'b0;
      act_data_q <= '0;
      act_dp_q   <= '0;
      act_en_q   <= '0;
    end else begin
      if (bus.load_i) begin
        sh_data_q <= bus.data_i;
        sh_dp_q   <= bus.dp_i;
        sh_en_q   <= bus.en_i;
      end
      if (wrap && pend_q) begin
        act_data_q <= sh_data_q;
        act_dp_q   <= sh_dp_q;
        act_en_q   <= sh_en_q;
      end
      if (bus.load_i)  pend_q <= 1'b1;
      else if (wrap)   pend_q <= 1'b0;
    end
  end

  assign bus.an_o        = an_q;
  assign bus.seg_o       = seg_q;
  assign bus.dp_o        = dpo_q;
  assign bus.digit_idx_o = didx_q;

endmodule

// File: doc/seg7_scan_ctrl.md
SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 SHALL have parameter BLANK_CYC, default 4, meaning clk_i cycles of all-anodes-off inserted before each digit; legal range 1..255.
REQ-002 SHALL have port clk_i  input  1  system clock.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port scan_clk_i  input  1  1 kHz scan clock, 50% duty, from the display clock divider; one digit step per rising edge.
REQ-005 SHALL have port data_i  input  32  eight hex digits; digit k = data_i[4k+3:4k].
REQ-006 SHALL have port dp_i  input  8  decimal point per digit, 1 = lit.
REQ-007 SHALL have port en_i  input  8  digit enable per digit, 1 = shown.
REQ-008 SHALL have port load_i  input  1  one-cycle strobe capturing data_i/dp_i/en_i into shadow registers.
REQ-009 SHALL have port an_o  output  8  anode select, active-low, registered.
REQ-010 SHALL have port seg_o  output  7  segments, active-low, bit0=a .. bit6=g, registered.
REQ-011 SHALL have port dp_o  output  1  decimal point, active-low, registered.
REQ-012 SHALL have port digit_idx_o  output  3  index of the current scan slot, registered.

Function
REQ-013 SHALL pass scan_clk_i through a 3-flop chain s1->s2->s3; step pulse = s2 & ~s3, exactly one clk_i cycle per scan_clk_i rising edge.
REQ-014 SHALL implement states BLANK and DRIVE; 8-bit blank counter bcnt.
REQ-015 On step, any state: idx <= idx+1 mod 8 (7 wraps to 0), state <= BLANK, bcnt <= BLANK_CYC-1.
REQ-016 In BLANK without step: an_o=8'hFF, seg_o=7'h7F, dp_o=1; bcnt decrements; at bcnt==0 the state moves to DRIVE. Blank interval = exactly BLANK_CYC cycles.
REQ-017 In DRIVE: an_o[idx]=0 only if active en[idx]=1, all other bits 1; seg_o = complement of the hex pattern of active digit idx; dp_o = ~active dp[idx] when enabled, else 1.
REQ-018 SHALL use gfedcba hex patterns: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-019 load_i=1 SHALL capture data_i, dp_i and en_i into shadow registers and set the pending flag; a later load overwrites the shadow.
REQ-020 When idx wraps 7->0 with pending=1, SHALL copy shadow to active registers and clear pending; mid-frame loads never alter the displayed frame (no tearing).
REQ-021 load_i coinciding with the wrap cycle: commit uses the pre-load shadow; the new load is captured and pending stays 1 for the next frame.
REQ-022 step arriving during BLANK SHALL restart the blank interval and advance idx again; no digit is driven.
REQ-023 digit_idx_o SHALL equal idx in both states.
REQ-024 Outputs SHALL be registered: changes in an_o/seg_o/dp_o appear one clk_i cycle after the state/idx update causing them.
REQ-025 scan_clk_i held constant SHALL freeze the display on the current digit indefinitely.

Reset
REQ-026 rst_i=0 SHALL immediately force: an_o=8'hFF, seg_o=7'h7F, dp_o=1, digit_idx_o=0, idx=0, state=BLANK, bcnt=BLANK_CYC-1, s1..s3=0, shadow=0, active=0 (en=0), pending=0.
REQ-027 After reset release the display SHALL stay dark (active en=0) until a load is committed at a 7->0 wrap.
REQ-028 Reset asserted mid-frame SHALL discard pending and shadow contents.

Verification
REQ-029 Reset, load data_i=32'h76543210, en_i=FF, dp_i=00, run 16 scan edges -> first frame dark; second frame shows an_o=FE seg_o=40, FD/79, FB/24, F7/30, EF/19, DF/12, BF/02, 7F/78.
REQ-030 BLANK_CYC=4, single scan edge -> exactly 4 cycles an_o=FF between consecutive digit drives.
REQ-031 load 32'hFFFFFFFF at idx=3 -> digits 4..7 keep old values; new value shown from idx 0 of the next frame.
REQ-032 load_i asserted on wrap cycle -> old shadow displayed this frame, new value the frame after.
REQ-033 en_i=8'h0F, dp_i=8'h01 -> an_o bits 7..4 stay 1 in their slots; dp_o=0 only in slot 0.
REQ-034 rst_i low during DRIVE of digit 5 -> an_o=FF, seg_o=7F, digit_idx_o=0 without waiting for clk_i.
